// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: DIFF = A - B, one bit per clock, LSB first.
// A single full-subtractor cell is reused every cycle, and the borrow is held in a flop between cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] DIFF,
    output logic             BORROW
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             borrow_q, borrow_d;
    logic             bit_diff, bit_borrow;

    function automatic logic fs_diff(input logic a, input logic b, input logic br);
        return a ^ b ^ br;
    endfunction

    function automatic logic fs_borrow(input logic a, input logic b, input logic br);
        return (~a & b) | (~(a ^ b) & br);
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            part_q   <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            part_q   <= part_d;
            diff_q   <= diff_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_RUN;
            S_RUN:   if (cnt_q == LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bit_diff   = fs_diff(opa_q[0], opb_q[0], br_q);
        bit_borrow = fs_borrow(opa_q[0], opb_q[0], br_q);
        opa_d      = opa_q;
        opb_d      = opb_q;
        part_d     = part_q;
        diff_d     = diff_q;
        cnt_d      = cnt_q;
        br_d       = br_q;
        borrow_d   = borrow_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    opa_d  = A;
                    opb_d  = B;
                    part_d = '0;
                    cnt_d  = '0;
                    br_d   = 1'b0;
                end
            end
            S_RUN: begin
                opa_d  = opa_q >> 1;
                opb_d  = opb_q >> 1;
                part_d = {bit_diff, part_q[WIDTH-1:1]};
                br_d   = bit_borrow;
                cnt_d  = cnt_q + CNT_W'(1);
                // The result registers only change on the final bit, so they never show partial values.
                if (cnt_q == LAST) begin
                    diff_d   = {bit_diff, part_q[WIDTH-1:1]};
                    borrow_d = bit_borrow;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        BUSY = (state_q == S_RUN);
        DONE = (state_q == S_DONE);
    end

    assign DIFF   = diff_q;
    assign BORROW = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit instance for directed scenarios
// and a 4-bit instance for the exhaustive sweep.
module tb_serial_subtractor;
    logic       CLK = 1'b0;
    logic       RST;
    logic       start8, busy8, done8, borrow8;
    logic [7:0] a8, b8, diff8;
    logic       start4, busy4, done4, borrow4;
    logic [3:0] a4, b4, diff4;

    int         checks = 0;
    int         failures = 0;
    logic [8:0] exp_q[$];
    logic [4:0] exp4_q[$];
    logic [7:0] last_diff;
    logic       last_borrow;

    always #5 CLK = ~CLK;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .CLK(CLK), .RST(RST), .START(start8), .A(a8), .B(b8),
        .BUSY(busy8), .DONE(done8), .DIFF(diff8), .BORROW(borrow8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .CLK(CLK), .RST(RST), .START(start4), .A(a4), .B(b4),
        .BUSY(busy4), .DONE(done4), .DIFF(diff4), .BORROW(borrow4)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_op8(input logic [7:0] a, input logic [7:0] b);
        int edges;
        logic [8:0] exp;
        @(negedge CLK);
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            failures++;
            $display("FAIL idle_before_start busy=%b done=%b required 0/0", busy8, done8);
        end
        start8 = 1'b1;
        a8 = a;
        b8 = b;
        exp_q.push_back({1'b0, a} - {1'b0, b});
        @(posedge CLK);
        @(negedge CLK);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        edges = 0;
        while (done8 !== 1'b1 && edges < 12) begin
            checks++;
            if (busy8 !== 1'b1 || diff8 !== last_diff || borrow8 !== last_borrow) begin
                failures++;
                $display("FAIL run_hold edge=%0d busy=%b diff=%h borrow=%b required 1/%h/%b",
                         edges, busy8, diff8, borrow8, last_diff, last_borrow);
            end
            @(negedge CLK);
            edges++;
        end
        checks++;
        if (edges != 8) begin
            failures++;
            $display("FAIL latency a=%h b=%h edges=%0d required 8", a, b, edges);
        end
        checks++;
        if (busy8 !== 1'b0) begin
            failures++;
            $display("FAIL busy_at_done busy=%b required 0", busy8);
        end
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty a=%h b=%h", a, b);
        end else begin
            exp = exp_q.pop_front();
            if ({borrow8, diff8} !== exp) begin
                failures++;
                $display("FAIL result a=%h b=%h got borrow=%b diff=%h required borrow=%b diff=%h",
                         a, b, borrow8, diff8, exp[8], exp[7:0]);
            end
            last_diff = exp[7:0];
            last_borrow = exp[8];
        end
        @(negedge CLK);
        checks++;
        if (done8 !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse_width done=%b required 0", done8);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0 || {busy4, done4, diff4, borrow4} !== 7'd0) begin
            failures++;
            $display("FAIL reset_state busy=%b done=%b diff=%h borrow=%b required zeros",
                     busy8, done8, diff8, borrow8);
        end
        RST = 1'b0;
        last_diff = '0;
        last_borrow = 1'b0;
    endtask

    task automatic test_basic();
        run_op8(8'h5A, 8'h3C);
    endtask

    task automatic test_borrow_cases();
        run_op8(8'h00, 8'h01);
        run_op8(8'hFF, 8'hFF);
        run_op8(8'h3C, 8'h5A);
        run_op8(8'h80, 8'h7F);
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic [8:0] exp;
        ndone = 0;
        @(negedge CLK);
        start8 = 1'b1;
        a8 = 8'h77;
        b8 = 8'h11;
        exp_q.push_back({1'b0, 8'h77} - {1'b0, 8'h11});
        @(posedge CLK);
        @(negedge CLK);
        a8 = 8'h11;
        b8 = 8'h22;
        exp_q.push_back({1'b0, 8'h11} - {1'b0, 8'h22});
        for (int e = 1; e <= 24; e++) begin
            @(negedge CLK);
            if (e == 10) start8 = 1'b0;
            if (e == 9 || e == 10) begin
                checks++;
                if (busy8 !== (e == 10)) begin
                    failures++;
                    $display("FAIL reaccept edge=%0d busy=%b required %b", e, busy8, (e == 10));
                end
            end
            if (done8 === 1'b1) begin
                ndone++;
                checks++;
                if (e != ((ndone == 1) ? 8 : 18)) begin
                    failures++;
                    $display("FAIL b2b_latency done#%0d at edge %0d required %0d",
                             ndone, e, (ndone == 1) ? 8 : 18);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra_done at edge %0d", e);
                end else begin
                    exp = exp_q.pop_front();
                    if ({borrow8, diff8} !== exp) begin
                        failures++;
                        $display("FAIL b2b_result got borrow=%b diff=%h required borrow=%b diff=%h",
                                 borrow8, diff8, exp[8], exp[7:0]);
                    end
                    last_diff = exp[7:0];
                    last_borrow = exp[8];
                end
            end
        end
        checks++;
        if (ndone != 2) begin
            failures++;
            $display("FAIL b2b_done_count got %0d required 2", ndone);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge CLK);
        start8 = 1'b1;
        a8 = 8'h5A;
        b8 = 8'h3C;
        @(posedge CLK);
        @(negedge CLK);
        start8 = 1'b0;
        repeat (4) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, diff8, borrow8} !== 11'd0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b diff=%h borrow=%b required zeros",
                     busy8, done8, diff8, borrow8);
        end
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        last_diff = '0;
        last_borrow = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_activity cycle=%0d busy=%b done=%b required 0/0",
                         i, busy8, done8);
            end
        end
        run_op8(8'h09, 8'h03);
    endtask

    task automatic test_exhaustive4();
        int edges;
        logic [4:0] exp;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                @(negedge CLK);
                start4 = 1'b1;
                a4 = 4'(ia);
                b4 = 4'(ib);
                exp4_q.push_back({1'b0, 4'(ia)} - {1'b0, 4'(ib)});
                @(posedge CLK);
                @(negedge CLK);
                start4 = 1'b0;
                a4 = 4'($urandom);
                b4 = 4'($urandom);
                edges = 0;
                while (done4 !== 1'b1 && edges < 8) begin
                    @(negedge CLK);
                    edges++;
                end
                checks++;
                if (edges != 4) begin
                    failures++;
                    $display("FAIL w4_latency a=%h b=%h edges=%0d required 4", ia, ib, edges);
                end
                checks++;
                if (exp4_q.size() == 0) begin
                    failures++;
                    $display("FAIL w4_scoreboard_empty a=%h b=%h", ia, ib);
                end else begin
                    exp = exp4_q.pop_front();
                    if ({borrow4, diff4} !== exp) begin
                        failures++;
                        $display("FAIL w4_result a=%h b=%h got borrow=%b diff=%h required borrow=%b diff=%h",
                                 ia, ib, borrow4, diff4, exp[4], exp[3:0]);
                    end
                end
                @(negedge CLK);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow_cases();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
